core_wb_master: RTL and testbench

Wishbone classic single-transfer initiator that turns a valid/ready load/store request from the core into one bus cycle on the `core_soc_*` slave port of the SoC peripheral interconnect. It returns read data through a valid/ready response channel. At most one transaction is outstanding at a time. An optional timeout aborts cycles that no peripheral acknowledges.

---
 rtl/core_wb_master.sv | 129 ++++++++++++
 tb/tb_core_wb_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_master.sv
// Single-outstanding Wishbone classic initiator: core valid/ready request -> one bus cycle -> valid/ready response.
// Optional bus-wait timeout (abort with error) is built only when CORE_WB_TIMEOUT_EN is defined.
`ifndef WB_AD_WIDTH
`define WB_AD_WIDTH 32
`endif
`ifndef WB_DAT_WIDTH
`define WB_DAT_WIDTH 32
`endif

module core_wb_master #(
  parameter int AW          = `WB_AD_WIDTH,
  parameter int DW          = `WB_DAT_WIDTH,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_addr_o,
  output logic [DW-1:0]   wbm_wdata_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_rdata_i,
  input  logic            wbm_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state;

  // Ready is derived from state so it rises in the cycle right after a response is taken,
  // and is masked by the asynchronous reset itself.
  assign req_ready_o = (state == IDLE) && !rst;
  assign wbm_stb_o   = wbm_cyc_o;

`ifdef CORE_WB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_cnt;
  logic        err_q;

  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wbm_cyc_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_addr_o  <= '0;
      wbm_wdata_o <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
`ifdef CORE_WB_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            state       <= BUS;
            wbm_cyc_o   <= 1'b1;
            wbm_we_o    <= req_we_i;
            wbm_addr_o  <= req_addr_i;
            wbm_wdata_o <= req_wdata_i;
            wbm_sel_o   <= req_sel_i;
`ifdef CORE_WB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        BUS: begin
          // Ack is checked first so an ack on the timeout edge still completes normally.
          if (wbm_ack_i) begin
            state       <= RESP;
            wbm_cyc_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_addr_o  <= '0;
            wbm_wdata_o <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= wbm_we_o ? '0 : wbm_rdata_i;
`ifdef CORE_WB_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (wait_cnt == TO_LAST) begin
            state       <= RESP;
            wbm_cyc_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_addr_o  <= '0;
            wbm_wdata_o <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            err_q       <= 1'b1;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt    <= wait_cnt + 16'd1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
`ifdef CORE_WB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb_master.sv
// Directed bench for core_wb_master: expected responses are queued when a request is driven and popped on response.
module tb_core_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc, stb, wb_we, wb_ack;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  core_wb_master #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wb_we), .wbm_addr_o(wb_addr),
    .wbm_wdata_o(wb_wdata), .wbm_sel_o(wb_sel), .wbm_rdata_i(wb_rdata), .wbm_ack_i(wb_ack)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge following the next rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
  endtask

  // Pops the expected response, compares, then hands the response back.
  task automatic collect(input string tag);
    logic [32:0] e;
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e[31:0]);
      check({tag, "_err"}, rsp_err, e[32]);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_dropped"}, rsp_valid, 1'b0);
    check({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    int n;
    int acc;
    int nrsp;
    int acc_cyc[3];
    logic bad;
    logic [32:0] e;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
    tick();
    tick();
    check("rst_ready", req_ready, 1'b0);
    check("rst_ctl", {rsp_valid, rsp_err, cyc, stb, wb_we}, 5'b0);
    check("rst_data", {rsp_rdata, wb_addr, wb_wdata, wb_sel}, '0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1'b1);
    @(negedge clk);

    // Read with ack in the first bus cycle.
    drive_req(1'b0, 32'h0200_0000, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    tick();
    req_valid = 1'b0;
    check("rd_bus", {cyc, stb, wb_we, wb_addr, wb_sel, req_ready}, {3'b110, 32'h0200_0000, 4'hF, 1'b0});
    wb_ack = 1'b1; wb_rdata = 32'hDEAD_BEEF;
    tick();
    wb_ack = 1'b0; wb_rdata = '0;
    check("rd_cyc_one_cycle", {cyc, stb, rsp_valid}, 3'b001);
    collect("rd");

    // Write with five wait cycles then ack; response stalled four cycles.
    drive_req(1'b1, 32'h0200_0010, 32'h1234_5678, 4'h3);
    exp_q.push_back({1'b0, 32'h0});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("wr_fields", {cyc, stb, wb_we, wb_addr, wb_wdata, wb_sel},
            {3'b111, 32'h0200_0010, 32'h1234_5678, 4'h3});
      if (i == 5) begin
        wb_ack = 1'b1; wb_rdata = 32'hAAAA_5555;
      end
      tick();
    end
    wb_ack = 1'b0; wb_rdata = '0;
    check("wr_fields_cleared", {cyc, stb, wb_we, wb_addr, wb_wdata, wb_sel}, '0);
    for (int i = 0; i < 4; i++) begin
      check("wr_stall_hold", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
      tick();
    end
    collect("wr");

`ifdef CORE_WB_TIMEOUT_EN
    // No ack: abort after eight bus cycles, late ack ignored.
    drive_req(1'b0, 32'h0200_0020, 32'h0, 4'hF);
    exp_q.push_back({1'b1, 32'h0});
    wb_rdata = 32'h7777_7777;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (cyc && n < 20) begin
      n++;
      tick();
    end
    check("to_cyc_cycles", n, 8);
    check("to_rsp_valid", rsp_valid, 1'b1);
    tick();
    tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0; wb_rdata = '0;
    check("to_late_ack_ignored", {cyc, rsp_valid, rsp_err, rsp_rdata}, {3'b011, 32'h0});
    collect("to");
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bad = bad | rsp_valid | cyc;
      tick();
    end
    check("to_no_second_rsp", bad, 1'b0);

    // Ack arriving on the timeout edge wins.
    drive_req(1'b0, 32'h0200_0024, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("to_edge_still_bus", cyc, 1'b1);
    wb_ack = 1'b1; wb_rdata = 32'hCAFE_F00D;
    tick();
    wb_ack = 1'b0; wb_rdata = '0;
    check("to_edge_rsp", {cyc, rsp_valid}, 2'b01);
    collect("to_edge");
`endif

    // Asynchronous reset during a bus cycle.
    drive_req(1'b0, 32'h0200_0030, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_rst_bus", {cyc, stb}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_async", {cyc, stb, req_ready, rsp_valid}, 4'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_idle", {req_ready, rsp_valid, cyc}, 3'b100);
    drive_req(1'b0, 32'h0200_0004, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'h0BAD_CAFE});
    tick();
    req_valid = 1'b0;
    check("post_rst_addr", {cyc, wb_addr}, {1'b1, 32'h0200_0004});
    wb_ack = 1'b1; wb_rdata = 32'h0BAD_CAFE;
    tick();
    wb_ack = 1'b0; wb_rdata = '0;
    wait_valid("post_rst", 5);
    collect("post_rst");

    // Valid held high, three reads, immediate ack, consumer always ready.
    req_valid = 1'b1; req_we = 1'b0; req_sel = 4'hF; rsp_ready = 1'b1;
    acc = 0; nrsp = 0; bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      wb_ack   = cyc;
      wb_rdata = cyc ? (wb_addr ^ 32'h5A5A_0000) : 32'h0;
      if (acc == 3) req_valid = 1'b0;
      else          req_addr  = 32'h0200_0100 + 32'(acc * 4);
      if (rsp_valid) begin
        nrsp++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("b2b_rdata", {rsp_err, rsp_rdata}, e);
        end else begin
          bad = 1'b1;
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc[acc] = c;
        exp_q.push_back({1'b0, req_addr ^ 32'h5A5A_0000});
        acc++;
      end
      if ((rsp_valid && cyc) || exp_q.size() > 1) bad = 1'b1;
      tick();
    end
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
    check("b2b_accepts", acc, 3);
    check("b2b_responses", nrsp, 3);
    check("b2b_single_outstanding", bad, 1'b0);
    check("b2b_spacing", {acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]}, {32'd3, 32'd3});

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
